// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit between the core datapath and a req/gnt/rvalid data memory
//
// Purpose:
//   Captures one load or store from the core and runs it as a req/gnt
//   (+ rvalid for loads) memory transaction. It builds the byte enables and
//   the lane-replicated store data, and returns sign/zero-extended load data.
//   The core is held on stall until the access completes.
//
// Optional feature (macro LSU_MISALIGN_TRAP_EN):
//   defined   - misaligned half/word accesses skip the memory, go straight to
//               DONE and raise misalign_fault alongside core_done.
//   undefined - misaligned low address bits are ignored; misalign_fault = 0.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   core_req/we/funct3    access request, direction and RISC-V size/sign code
//   core_addr/wdata       byte address and store data from the datapath
//   core_rdata            extended load data, valid while core_done = 1
//   core_done             one-cycle completion pulse
//   stall                 freeze PC/pipeline while high
//   misalign_fault        misaligned-access flag (trap build only)
//   mem_req/we/addr/be    memory request (held until mem_gnt), word address, byte enables
//   mem_wdata             lane-aligned store data
//   mem_gnt               request accepted this cycle
//   mem_rvalid/rdata      read data return
module lsu_mem_ctrl #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [2:0]            core_funct3,
  input  logic [31:0]           core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_done,
  output logic                  stall,
  output logic                  misalign_fault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Byte-address bits actually needed: word address plus the lane offset.
  localparam int AW = DM_ADDRESS + 2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata_lane;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [DATA_W-1:0] load_ext;
  logic              misalign_now;
  logic              unused_addr_hi;

  // Address bits above the data memory range never reach the memory.
  assign unused_addr_hi = ^core_addr[31:AW];

`ifdef LSU_MISALIGN_TRAP_EN
  logic fault_q;

  // funct3[1:0]: 00 byte, 01 half, 1x word.
  assign misalign_now = ((core_funct3[1:0] == 2'b01) && core_addr[0]) ||
                        (core_funct3[1] && (core_addr[1:0] != 2'b00));

  // Refreshed on every accepted request, so a trap never leaks into the
  // next transaction's DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else if ((state == ST_IDLE) && core_req) begin
      fault_q <= misalign_now;
    end
  end

  assign misalign_fault = (state == ST_DONE) && fault_q;
`else
  assign misalign_now   = 1'b0;
  assign misalign_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rdata <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && core_req) begin
        we_q    <= core_we;
        f3_q    <= core_funct3;
        addr_q  <= core_addr[AW-1:0];
        wdata_q <= core_wdata;
      end
      // Only a load in WAIT updates core_rdata; stores and stray rvalids leave it.
      if ((state == ST_WAIT) && mem_rvalid) begin
        core_rdata <= load_ext;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (core_req) begin
          state_nxt = misalign_now ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          state_nxt = we_q ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign lane = addr_q[1:0];

  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be         = 4'b0001 << lane;
        wdata_lane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be         = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata_q[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata_q;
      end
    endcase
  end

  always_comb begin
    rd_byte = mem_rdata[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_ext = {24'd0, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_ext = {16'd0, rd_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Memory-side outputs are zero outside REQ so a parked LSU presents nothing.
  assign mem_req   = (state == ST_REQ);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? addr_q[AW-1:2] : '0;
  assign mem_be    = mem_req ? be : 4'b0000;
  assign mem_wdata = mem_req ? wdata_lane : '0;

  assign core_done = (state == ST_DONE);

  // The IDLE term is combinational on core_req; gate it with reset so stall
  // stays low while reset is held.
  assign stall = reset && (((state == ST_IDLE) && core_req) ||
                           (state == ST_REQ) || (state == ST_WAIT));

endmodule
